// File: rtl/spi_word_master.sv
// Mode-0 SPI initiator: one MSB-bit word per start request, CS active-high, MSB first.
// Optional MISO capture into dout is enabled by defining SPI_WORD_MASTER_MISO_EN.
module spi_word_master #(
  parameter int unsigned MSB     = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [MSB-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [MSB-1:0] dout,
  output logic           SCLK,
  output logic           CS,
  output logic           MOSI,
  input  logic           MISO
);

  localparam int unsigned PhW  = $clog2(CLK_DIV) + 1;
  localparam int unsigned BitW = $clog2(MSB);
  localparam logic [PhW-1:0]  PhLast   = PhW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitFirst = BitW'(MSB - 1);

  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StTrail} state_e;

  state_e          state_q;
  logic [PhW-1:0]  phase_q;
  logic [BitW-1:0] bit_q;
  logic [MSB-1:0]  sh_q;
  logic            sclk_q;
  logic            cs_q;
  logic            busy_q;
  logic            done_q;
  logic            phase_end;

  assign phase_end = (phase_q == PhLast);

  // MOSI is the top bit of the shift register, which is cleared outside a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle) begin
        phase_q <= phase_end ? '0 : phase_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            sh_q    <= din;
            bit_q   <= BitFirst;
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            phase_q <= '0;
            state_q <= StLead;
          end
        end
        StLead, StLow: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (bit_q != '0) begin
              sh_q    <= sh_q << 1;
              bit_q   <= bit_q - 1'b1;
              state_q <= StLow;
            end else begin
              state_q <= StTrail;
            end
          end
        end
        StTrail: begin
          if (phase_end) begin
            cs_q    <= 1'b0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign SCLK = sclk_q;
  assign CS   = cs_q;
  assign MOSI = sh_q[MSB-1];
  assign busy = busy_q;
  assign done = done_q;

`ifdef SPI_WORD_MASTER_MISO_EN
  logic [MSB-1:0] rx_q;
  logic [MSB-1:0] dout_q;
  logic           sclk_rise;

  assign sclk_rise = phase_end && ((state_q == StLead) || (state_q == StLow));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q   <= '0;
      dout_q <= '0;
    end else begin
      if (sclk_rise) begin
        rx_q <= {rx_q[MSB-2:0], MISO};
      end
      if ((state_q == StTrail) && phase_end) begin
        dout_q <= rx_q;
      end
    end
  end

  assign dout = dout_q;
`else
  logic unused_miso;
  assign unused_miso = MISO;
  assign dout        = '0;
`endif

endmodule
